rr_hold_arbiter: RTL and testbench

//  Round-robin arbiter with bounded grant hold, for sharing one resource among
//  N requesters. Successor to the fixed-priority arbiter: same REQ/GNT

---
 rtl/rr_hold_arbiter.sv | 122 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a bounded grant hold. A granted requester keeps the
// resource while it requests. It is preempted after MAX_HOLD cycles if another
// requester is waiting. Grants are registered and take one cycle after REQ.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  localparam int ID_W    = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    REQ,
  output logic [N-1:0]    GNT,
  output logic [ID_W-1:0] GNT_ID,
  output logic            BUSY,
  output logic            EXPIRE
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              exp_q, exp_d;
  logic [ID_W-1:0]   nxt;
  logic [N-1:0]      others;

  // Find the first set bit at or after start, wrapping cyclically.
  function automatic logic [ID_W-1:0] search(input logic [N-1:0] r,
                                             input logic [ID_W-1:0] start);
    logic found;
    int   idx;
    search = start;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && r[idx]) begin
        search = ID_W'(idx);
        found  = 1'b1;
      end
    end
  endfunction

  // Return the index that follows o, wrapping from N-1 to 0.
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] o);
    inc_id = (o == ID_W'(N - 1)) ? '0 : o + ID_W'(1);
  endfunction

  // Choose the next owner, the hold count and the search pointer from the REQ bits sampled at this edge.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    exp_d   = 1'b0;
    nxt     = inc_id(id_q);
    others  = REQ & ~gnt_q;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = GRANT;
          id_d    = search(REQ, ptr_q);
          hold_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!REQ[id_q]) begin
          // The owner released. Hand over directly, or go idle if nobody is requesting.
          ptr_d = nxt;
          if (|REQ) begin
            id_d   = search(REQ, nxt);
            hold_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (hold_q == CNT_W'(MAX_HOLD)) begin
          // The hold limit is reached. Preempt only when someone else is waiting.
          // Otherwise the count stays saturated.
          if (|others) begin
            ptr_d  = nxt;
            id_d   = search(REQ, nxt);
            hold_d = CNT_W'(1);
            exp_d  = 1'b1;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (N'(1) << id_d) : '0;
  end

  // Register the state. An asynchronous reset drops the grant at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
    end
  end

  assign GNT    = gnt_q;
  assign GNT_ID = id_q;
  assign BUSY   = (state_q == GRANT);
  assign EXPIRE = exp_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed and random stimulus for rr_hold_arbiter. Outputs are compared
// against a small owner/queue reference model.
module tb_rr_hold_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 4;
  localparam int BOUND = (N - 1) * MAXH + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] GNT;
  logic [1:0]   GNT_ID;
  logic         BUSY, EXPIRE;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the current owner (-1 when idle), cycles held, and the search start.
  int own = -1, held = 0, ptr = 0;
  bit m_exp = 1'b0;
  int waitc [N];
  int expires = 0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .REQ(REQ),
    .GNT(GNT), .GNT_ID(GNT_ID), .BUSY(BUSY), .EXPIRE(EXPIRE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1; held = 0; ptr = 0; m_exp = 1'b0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    m_exp = 1'b0;
    if (own < 0) begin
      if (r != 0) begin own = first_from(r, ptr); held = 1; end
    end else if (!r[own]) begin
      ptr = (own + 1) % N;
      if (r != 0) begin own = first_from(r, ptr); held = 1; end
      else begin own = -1; held = 0; end
    end else if (held == MAXH) begin
      if ((r & ~(N'(1) << own)) != 0) begin
        ptr = (own + 1) % N;
        own = first_from(r, ptr);
        held = 1;
        m_exp = 1'b1;
      end
    end else begin
      held++;
    end
  endtask

  task automatic check_outputs(input logic [N-1:0] r);
    logic [N-1:0] eg;
    int maxw;
    eg = (own < 0) ? '0 : (N'(1) << own);
    chk("GNT", 32'(GNT), 32'(eg));
    chk("GNT_ID", 32'(GNT_ID), (own < 0) ? 0 : own);
    chk("BUSY", 32'(BUSY), 32'(own >= 0));
    chk("EXPIRE", 32'(EXPIRE), 32'(m_exp));
    chk("onehot0", 32'($onehot0(GNT)), 1);
    chk("gnt_subset_req", 32'(GNT & ~r), 0);
    maxw = 0;
    for (int i = 0; i < N; i++) begin
      if (r[i] && !GNT[i]) waitc[i]++; else waitc[i] = 0;
      if (waitc[i] > maxw) maxw = waitc[i];
    end
    chk("starve_bound", 32'(maxw <= BOUND), 1);
    if (EXPIRE === 1'b1) expires++;
  endtask

  // Drive REQ, let the edge happen, then check 1 ns later.
  task automatic step(input logic [N-1:0] r);
    REQ = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs(r);
  endtask

  // Assert reset between edges. The outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_gnt"}, 32'(GNT), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    model_reset();
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();
    // Test 1: reset is held with all requests active, then the design idles after release.
    REQ = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_id", 32'(GNT_ID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_exp", 32'(EXPIRE), 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) step(4'b0000);

    // Test 2: direct handover with no idle gap.
    do_reset("t2");
    step(4'b1010); chk("t2_gnt1", 32'(GNT), 32'h2); chk("t2_id1", 32'(GNT_ID), 1);
    step(4'b1000); chk("t2_gnt3", 32'(GNT), 32'h8); chk("t2_busy", 32'(BUSY), 1);
    step(4'b0000); chk("t2_idle", 32'(BUSY), 0);

    // Test 3: full contention rotates every MAX_HOLD edges.
    do_reset("t3");
    expires = 0;
    for (int e = 0; e < 17; e++) begin
      step(4'b1111);
      chk("t3_rot", 32'(GNT), 32'(1 << ((e / MAXH) % N)));
    end
    chk("t3_expire_cnt", 32'(expires), 4);

    // Test 4: a lone holder saturates, then a newcomer preempts it at once.
    do_reset("t4");
    expires = 0;
    repeat (10) step(4'b0100);
    chk("t4_no_expire", 32'(expires), 0);
    step(4'b0101);
    chk("t4_gnt", 32'(GNT), 32'h1);
    chk("t4_exp", 32'(EXPIRE), 1);
    step(4'b0101);
    chk("t4_exp_pulse", 32'(EXPIRE), 0);

    // Test 5: reset in the middle of a grant, and ptr returns to 0.
    do_reset("t5");
    step(4'b0010);
    step(4'b0010);
    do_reset("t5mid");
    step(4'b1001);
    chk("t5_gnt", 32'(GNT), 32'h1);

    // Test 6: random requests with persistence.
    do_reset("t6");
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
